// File: rtl/agc_seq_pkg.sv
// Shared types and constants for the AGC gain sequencer.
package agc_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_COLLECT,
      ST_REQUEST,
      ST_WAIT_GAIN,
      ST_ARM
   } seqState_t;

   localparam int CTRL_EN         = 0;
   localparam int CTRL_FREEZE     = 1;
   localparam int CTRL_PERIOD_LSB = 8;

   function automatic logic [31:0] unityGain(input int widthGain, input int intBits);
      return 32'd1 << (widthGain - intBits);
   endfunction

endpackage

// File: rtl/pkt_boundary_mon.sv
// Passive tap on the sample stream: tracks packet state, counts packets and
// flags edges where a gain swap cannot split a packet.
module pkt_boundary_mon (
   input  logic       clk,
   input  logic       reset,
   input  logic       tvalid_i,
   input  logic       tready_i,
   input  logic       tlast_i,
   input  logic       clearCnt_i,
   output logic [7:0] pktCnt_o,
   output logic       boundary_o
);

   logic       beat;
   logic       inPkt_q, inPkt_d;
   logic [7:0] pktCnt_q, pktCnt_d;

   assign beat = tvalid_i & tready_i;

   // Clearing wins over a coincident tlast so a fresh collection window starts at zero.
   always_comb begin
      inPkt_d  = inPkt_q;
      pktCnt_d = pktCnt_q;
      if (beat) begin
         inPkt_d = !tlast_i;
      end
      if (clearCnt_i) begin
         pktCnt_d = '0;
      end else if (beat && tlast_i && (pktCnt_q != 8'hFF)) begin
         pktCnt_d = pktCnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         inPkt_q  <= 1'b0;
         pktCnt_q <= '0;
      end else begin
         inPkt_q  <= inPkt_d;
         pktCnt_q <= pktCnt_d;
      end
   end

   assign pktCnt_o   = pktCnt_q;
   assign boundary_o = (beat & tlast_i) | (!inPkt_q & !beat);

endmodule

// File: rtl/setting_reg.sv
// One addressable settings register; loads on a matching strobe, visible the next cycle.
module setting_reg #(
   parameter logic [7:0]       ADDR        = 8'd0,
   parameter int               WIDTH       = 32,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             strobe_i,
   input  logic [7:0]       addr_i,
   input  logic [31:0]      data_i,
   output logic [WIDTH-1:0] value_o
);

   logic [WIDTH-1:0] value_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         value_q <= RESET_VALUE;
      end else if (strobe_i && (addr_i == ADDR)) begin
         value_q <= data_i[WIDTH-1:0];
      end
   end

   assign value_o = value_q;

   generate
      if (WIDTH < 32) begin : gNarrow
         logic unusedHighBits;
         assign unusedHighBits = ^data_i[31:WIDTH];
      end
   endgenerate

endmodule

// File: rtl/agc_gain_sequencer.sv
// Gain-path controller of the feed-forward AGC: throttles magnitudes into the
// divider, clamps returned gains and swaps them in only on packet boundaries.
module agc_gain_sequencer
   import agc_seq_pkg::*;
#(
   parameter int                    WIDTH_MAG        = 16,
   parameter int                    WIDTH_GAIN       = 16,
   parameter int                    NUM_INTEGER_BITS = 3,
   parameter logic [WIDTH_GAIN-1:0] DEFAULT_GAIN     = 16'h2000,
   parameter int                    SR_CTRL          = 0,
   parameter int                    SR_DEFAULT_GAIN  = 1,
   parameter int                    SR_MAX_GAIN      = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  set_stb,
   input  logic [7:0]            set_addr,
   input  logic [31:0]           set_data,
   input  logic [WIDTH_MAG-1:0]  mag_tdata,
   input  logic                  mag_tvalid,
   output logic                  mag_tready,
   output logic [WIDTH_MAG-1:0]  div_tdata,
   output logic                  div_tvalid,
   input  logic                  div_tready,
   input  logic [WIDTH_GAIN-1:0] gain_in_tdata,
   input  logic                  gain_in_tvalid,
   output logic                  gain_in_tready,
   output logic [WIDTH_GAIN-1:0] gain_out_tdata,
   output logic                  gain_out_tvalid,
   input  logic                  gain_out_tready,
   input  logic                  s_tlast,
   input  logic                  s_tvalid,
   input  logic                  s_tready
);

   logic [15:0]           ctrlReg;
   logic [WIDTH_GAIN-1:0] defaultGain;
   logic [WIDTH_GAIN-1:0] maxGain;

   setting_reg #(.ADDR(SR_CTRL[7:0]), .WIDTH(16), .RESET_VALUE(16'h0000)) ctrlSr (
      .clk(clk), .reset(reset), .strobe_i(set_stb), .addr_i(set_addr),
      .data_i(set_data), .value_o(ctrlReg)
   );

   setting_reg #(.ADDR(SR_DEFAULT_GAIN[7:0]), .WIDTH(WIDTH_GAIN), .RESET_VALUE(DEFAULT_GAIN)) defaultSr (
      .clk(clk), .reset(reset), .strobe_i(set_stb), .addr_i(set_addr),
      .data_i(set_data), .value_o(defaultGain)
   );

   setting_reg #(.ADDR(SR_MAX_GAIN[7:0]), .WIDTH(WIDTH_GAIN), .RESET_VALUE({WIDTH_GAIN{1'b1}})) maxSr (
      .clk(clk), .reset(reset), .strobe_i(set_stb), .addr_i(set_addr),
      .data_i(set_data), .value_o(maxGain)
   );

   logic       enable, freeze;
   logic [7:0] period, effPeriod;

   assign enable    = ctrlReg[CTRL_EN];
   assign freeze    = ctrlReg[CTRL_FREEZE];
   assign period    = ctrlReg[CTRL_PERIOD_LSB +: 8];
   assign effPeriod = (period == 8'd0) ? 8'd1 : period;

   seqState_t             state_q;
   logic [7:0]            pktCnt;
   logic                  boundary;
   logic                  enterCollect;
   logic                  collectGo;
   logic                  magReady_q, magFresh_q, gainValid_q;
   logic [WIDTH_MAG-1:0]  magReg_q, divData_q;
   logic                  divValid_q, gainReady_q, gotGain_q;
   logic [WIDTH_GAIN-1:0] pending_q, gainReg_q, clampedGain;
   logic                  magBeat;

   pkt_boundary_mon boundaryMon (
      .clk(clk), .reset(reset),
      .tvalid_i(s_tvalid), .tready_i(s_tready), .tlast_i(s_tlast),
      .clearCnt_i(enterCollect), .pktCnt_o(pktCnt), .boundary_o(boundary)
   );

   assign magBeat      = mag_tvalid & magReady_q;
   assign collectGo    = enable & !freeze & magFresh_q & (pktCnt >= effPeriod);
   assign enterCollect = enable & ((state_q == ST_IDLE) | ((state_q == ST_ARM) & (freeze | boundary)));
   assign clampedGain  = (gain_in_tdata > maxGain) ? maxGain : gain_in_tdata;

   // A magnitude landing on the issue edge keeps mag_fresh set, so it is not lost.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         magReady_q  <= 1'b0;
         gainValid_q <= 1'b0;
         magReg_q    <= '0;
         magFresh_q  <= 1'b0;
      end else begin
         magReady_q  <= 1'b1;
         gainValid_q <= 1'b1;
         if (magBeat) begin
            magReg_q   <= mag_tdata;
            magFresh_q <= 1'b1;
         end else if ((state_q == ST_COLLECT) && collectGo) begin
            magFresh_q <= 1'b0;
         end
      end
   end

   // WAIT_GAIN spends one extra cycle after the handshake before deciding to arm.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         divValid_q  <= 1'b0;
         divData_q   <= '0;
         gainReady_q <= 1'b0;
         gotGain_q   <= 1'b0;
         pending_q   <= '0;
         gainReg_q   <= DEFAULT_GAIN;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (boundary) gainReg_q <= defaultGain;
               if (enable) state_q <= ST_COLLECT;
            end
            ST_COLLECT: begin
               if (!enable) begin
                  state_q <= ST_IDLE;
               end else if (collectGo) begin
                  state_q    <= ST_REQUEST;
                  divValid_q <= 1'b1;
                  divData_q  <= magReg_q;
               end
            end
            ST_REQUEST: begin
               if (div_tready) begin
                  divValid_q  <= 1'b0;
                  gainReady_q <= 1'b1;
                  state_q     <= ST_WAIT_GAIN;
               end
            end
            ST_WAIT_GAIN: begin
               if (gotGain_q) begin
                  gotGain_q <= 1'b0;
                  state_q   <= (enable && !freeze) ? ST_ARM : ST_IDLE;
               end else if (gain_in_tvalid) begin
                  gainReady_q <= 1'b0;
                  gotGain_q   <= 1'b1;
                  pending_q   <= clampedGain;
               end
            end
            ST_ARM: begin
               if (!enable) begin
                  state_q <= ST_IDLE;
               end else if (freeze) begin
                  state_q <= ST_COLLECT;
               end else if (boundary) begin
                  gainReg_q <= pending_q;
                  state_q   <= ST_COLLECT;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign mag_tready      = magReady_q;
   assign div_tvalid      = divValid_q;
   assign div_tdata       = divData_q;
   assign gain_in_tready  = gainReady_q;
   assign gain_out_tdata  = gainReg_q;
   assign gain_out_tvalid = gainValid_q;

   // Inputs and constants this block deliberately ignores.
   logic [31:0] unusedSink;
   assign unusedSink = {25'd0, ^ctrlReg[7:2], gain_out_tready, 5'd0}
                       ^ unityGain(WIDTH_GAIN, NUM_INTEGER_BITS);

endmodule

// File: tb/tb_agc_gain_sequencer.sv
// Directed self-checking bench for agc_gain_sequencer.
module tb_agc_gain_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        set_stb;
   logic [7:0]  set_addr;
   logic [31:0] set_data;
   logic [15:0] mag_tdata;
   logic        mag_tvalid, mag_tready;
   logic [15:0] div_tdata;
   logic        div_tvalid, div_tready;
   logic [15:0] gain_in_tdata;
   logic        gain_in_tvalid, gain_in_tready;
   logic [15:0] gain_out_tdata;
   logic        gain_out_tvalid, gain_out_tready;
   logic        s_tlast, s_tvalid, s_tready;

   int checkCount = 0;
   int failCount  = 0;

   always #5 clk = ~clk;

   agc_gain_sequencer dut (
      .clk(clk), .reset(reset),
      .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
      .mag_tdata(mag_tdata), .mag_tvalid(mag_tvalid), .mag_tready(mag_tready),
      .div_tdata(div_tdata), .div_tvalid(div_tvalid), .div_tready(div_tready),
      .gain_in_tdata(gain_in_tdata), .gain_in_tvalid(gain_in_tvalid), .gain_in_tready(gain_in_tready),
      .gain_out_tdata(gain_out_tdata), .gain_out_tvalid(gain_out_tvalid), .gain_out_tready(gain_out_tready),
      .s_tlast(s_tlast), .s_tvalid(s_tvalid), .s_tready(s_tready)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One cycle on the monitored sample bus.
   task automatic applyStimulus(input logic sv, input logic st, input logic sl);
      s_tvalid = sv;
      s_tready = st;
      s_tlast  = sl;
      @(negedge clk);
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic setReg(input logic [7:0] addr, input logic [31:0] data);
      set_stb  = 1'b1;
      set_addr = addr;
      set_data = data;
      @(negedge clk);
      set_stb  = 1'b0;
   endtask

   task automatic sendMag(input logic [15:0] val);
      mag_tdata  = val;
      mag_tvalid = 1'b1;
      @(negedge clk);
      mag_tvalid = 1'b0;
   endtask

   task automatic waitDivValid(output logic got);
      got = 1'b0;
      for (int k = 0; k < 6 && !got; k++) begin
         if (div_tvalid) got = 1'b1;
         else @(negedge clk);
      end
   endtask

   task automatic divHandshake();
      div_tready = 1'b1;
      @(negedge clk);
      div_tready = 1'b0;
   endtask

   task automatic returnGain(input logic [15:0] val);
      gain_in_tdata  = val;
      gain_in_tvalid = 1'b1;
      @(negedge clk);
      gain_in_tvalid = 1'b0;
   endtask

   initial begin
      logic got;
      int   hsCount;

      reset = 1'b1;
      set_stb = 1'b0; set_addr = '0; set_data = '0;
      mag_tdata = '0; mag_tvalid = 1'b0;
      div_tready = 1'b0;
      gain_in_tdata = '0; gain_in_tvalid = 1'b0;
      gain_out_tready = 1'b0;
      s_tlast = 1'b0; s_tvalid = 1'b0; s_tready = 1'b0;
      tick(2);

      checkOutput("rstMagReady", mag_tready, 0);
      checkOutput("rstDivValid", div_tvalid, 0);
      checkOutput("rstDivData", div_tdata, 0);
      checkOutput("rstGainInReady", gain_in_tready, 0);
      checkOutput("rstGainOutValid", gain_out_tvalid, 0);
      checkOutput("rstGainOut", gain_out_tdata, 16'h2000);
      reset = 1'b0;
      tick(1);
      checkOutput("postRstMagReady", mag_tready, 1);
      checkOutput("postRstGainOutValid", gain_out_tvalid, 1);

      // Period 1: gain from the divider swaps in at the first tlast after return.
      setReg(8'd0, 32'h0000_0101);
      sendMag(16'h1000);
      applyStimulus(1, 1, 0);
      applyStimulus(1, 1, 1);
      waitDivValid(got);
      checkOutput("t1Request", got, 1);
      checkOutput("t1DivData", div_tdata, 16'h1000);
      divHandshake();
      checkOutput("t1GainInReady", gain_in_tready, 1);
      applyStimulus(1, 1, 0);
      returnGain(16'h4000);
      tick(3);
      checkOutput("t1MidPktGain", gain_out_tdata, 16'h2000);
      applyStimulus(1, 1, 0);
      checkOutput("t1MidPktGain2", gain_out_tdata, 16'h2000);
      applyStimulus(1, 1, 1);
      checkOutput("t1SwapGain", gain_out_tdata, 16'h4000);

      // Period 4: one request per four packets over twenty packets.
      setReg(8'd0, 32'h0000_0401);
      hsCount = 0;
      for (int i = 0; i < 20; i++) begin
         sendMag(16'(32'h0800 + i));
         applyStimulus(1, 1, 0);
         applyStimulus(1, 1, 1);
         waitDivValid(got);
         if (got) begin
            hsCount++;
            checkOutput("p4DivData", div_tdata, 32'h0800 + i);
            checkOutput("p4HsPacket", i % 4, 3);
            divHandshake();
            returnGain(16'h2400);
            tick(4);
         end
      end
      checkOutput("p4Handshakes", hsCount, 5);
      checkOutput("p4Gain", gain_out_tdata, 16'h2400);

      // Clamp against max_gain.
      setReg(8'd0, 32'h0000_0101);
      setReg(8'd2, 32'h0000_3000);
      sendMag(16'h0C00);
      applyStimulus(1, 1, 0);
      applyStimulus(1, 1, 1);
      waitDivValid(got);
      checkOutput("t3Request", got, 1);
      divHandshake();
      returnGain(16'hF000);
      tick(4);
      checkOutput("t3Clamped", gain_out_tdata, 16'h3000);

      // Freeze during WAIT_GAIN: result dropped, no requests while frozen.
      sendMag(16'h0900);
      applyStimulus(1, 1, 0);
      applyStimulus(1, 1, 1);
      waitDivValid(got);
      checkOutput("t4Request", got, 1);
      checkOutput("t4DivData", div_tdata, 16'h0900);
      divHandshake();
      applyStimulus(1, 1, 0);
      setReg(8'd0, 32'h0000_0103);
      checkOutput("t4GainInReady", gain_in_tready, 1);
      returnGain(16'h5000);
      tick(3);
      checkOutput("t4GainUnchanged", gain_out_tdata, 16'h3000);
      applyStimulus(1, 1, 1);
      sendMag(16'h0A00);
      tick(4);
      checkOutput("t4NoReqFrozen", div_tvalid, 0);
      checkOutput("t4GainStill", gain_out_tdata, 16'h3000);
      setReg(8'd0, 32'h0000_0101);
      waitDivValid(got);
      checkOutput("t4ReqAfterThaw", got, 1);
      checkOutput("t4ThawDivData", div_tdata, 16'h0A00);

      // Disable while REQUEST is stalled: valid holds, then drain and revert.
      setReg(8'd1, 32'h0000_1800);
      setReg(8'd0, 32'h0000_0100);
      for (int k = 0; k < 5; k++) begin
         checkOutput("t5HoldValid", div_tvalid, 1);
         tick(1);
      end
      checkOutput("t5GainBeforeDrain", gain_out_tdata, 16'h3000);
      divHandshake();
      checkOutput("t5DivDropped", div_tvalid, 0);
      checkOutput("t5GainInReady", gain_in_tready, 1);
      returnGain(16'h6000);
      tick(4);
      checkOutput("t5DefaultGain", gain_out_tdata, 16'h1800);

      // Asynchronous reset while armed.
      setReg(8'd0, 32'h0000_0101);
      sendMag(16'h0B00);
      applyStimulus(1, 1, 0);
      applyStimulus(1, 1, 1);
      waitDivValid(got);
      checkOutput("t6Request", got, 1);
      divHandshake();
      applyStimulus(1, 1, 0);
      returnGain(16'h4400);
      tick(2);
      checkOutput("t6ArmedGain", gain_out_tdata, 16'h1800);
      #2 reset = 1'b1;
      #1;
      checkOutput("t6AsyncMagReady", mag_tready, 0);
      checkOutput("t6AsyncDivValid", div_tvalid, 0);
      checkOutput("t6AsyncGainInReady", gain_in_tready, 0);
      checkOutput("t6AsyncGainOutValid", gain_out_tvalid, 0);
      checkOutput("t6AsyncGainOut", gain_out_tdata, 16'h2000);
      checkOutput("t6AsyncDivData", div_tdata, 0);
      @(negedge clk);
      reset = 1'b0;
      tick(1);
      checkOutput("t6PostGainOut", gain_out_tdata, 16'h2000);
      checkOutput("t6PostGainOutValid", gain_out_tvalid, 1);
      checkOutput("t6PostMagReady", mag_tready, 1);

      $display("%0d/%0d checks passed", checkCount - failCount, checkCount);
      $finish;
   end

endmodule

// File: doc/agc_gain_sequencer.md
# agc_gain_sequencer

Controller that owns the gain path of the feed-forward AGC. It accepts the magnitude estimate stream and throttles it into the gain divider at a programmable packet rate. It collects the rounded gain back from the divider, clamps it, and holds it as a persistent gain stream for the I/Q multipliers. New gains are swapped in only on packet boundaries of the monitored sample stream, so a packet is never scaled by two different gains.

## Interface
- WIDTH_MAG, 16: magnitude / dividend width.
- WIDTH_GAIN, 16: gain width, unsigned, NUM_INTEGER_BITS integer bits.
- NUM_INTEGER_BITS, 3: gain integer bits. Unity gain = 1 << (WIDTH_GAIN-NUM_INTEGER_BITS).
- DEFAULT_GAIN, 16'h2000: reset value of the default-gain register (unity for the defaults).
- SR_CTRL, 0: settings address. bit0 enable, bit1 freeze, [15:8] update period in packets (0 treated as 1).
- SR_DEFAULT_GAIN, 1: settings address; gain used while disabled.
- SR_MAX_GAIN, 2: settings address; upper clamp for gain. Resets to all ones.
- clk, in, 1: clock.
- reset, in, 1: asynchronous, active-high reset.
- set_stb, set_addr[7:0], set_data[31:0], in: settings bus.
- mag_tdata / mag_tvalid / mag_tready: in / in / out, WIDTH_MAG / 1 / 1. Magnitude estimates.
- div_tdata / div_tvalid / div_tready: out / out / in, WIDTH_MAG / 1 / 1. Dividend to the divider.
- gain_in_tdata / gain_in_tvalid / gain_in_tready: in / in / out, WIDTH_GAIN / 1 / 1. Rounded gain back from the divider.
- gain_out_tdata / gain_out_tvalid / gain_out_tready: out / out / in, WIDTH_GAIN / 1 / 1. Held gain to the multipliers.
- s_tlast, s_tvalid, s_tready, in, 1 each: passive tap on the sample-stream handshake.

## Operation
- Magnitude capture: mag_tready=1 outside reset. Each beat overwrites mag_reg and sets mag_fresh. mag_fresh clears when mag_reg is issued.
- Boundary tracking: beat = s_tvalid & s_tready.
  - in_pkt sets on a beat without tlast and clears on a beat with tlast.
  - pkt_cnt (8 bit, saturating) increments on each tlast beat and clears on entry to COLLECT.
- A boundary edge is a clock edge where either (beat & s_tlast), or (!in_pkt & !beat).
- FSM states: IDLE, COLLECT, REQUEST, WAIT_GAIN, ARM.
  - IDLE: if enable, go to COLLECT.
  - COLLECT: if !enable, go to IDLE. Otherwise, if !freeze & mag_fresh & pkt_cnt ≥ max(period,1), go to REQUEST.
  - REQUEST: div_tvalid=1, div_tdata=mag_reg (snapshot taken on entry). On div_tready, go to WAIT_GAIN. div_tvalid never drops before the handshake, even if enable clears.
  - WAIT_GAIN: gain_in_tready=1. On gain_in_tvalid, latch pending = min(gain_in_tdata, max_gain) (unsigned). Then go to ARM if enable & !freeze, else go to IDLE and discard the result.
  - ARM: on a boundary edge, gain_reg ← pending and go to COLLECT. If enable clears or freeze sets, discard pending and go to IDLE or COLLECT respectively.
- While in IDLE, on a boundary edge, gain_reg ← default_gain.
- gain_out_tdata = gain_reg. gain_out_tvalid=1 outside reset, independent of gain_out_tready (repeat semantics).
- Settings writes take effect the cycle after set_stb. A period change does not clear pkt_cnt.

## Timing
- Reset values: mag_tready=0, div_tvalid=0, div_tdata=0, gain_in_tready=0, gain_out_tvalid=0, gain_out_tdata=DEFAULT_GAIN, state=IDLE, pkt_cnt=0, in_pkt=0, mag_fresh=0.
- Cycle after reset deasserts: mag_tready=1, gain_out_tvalid=1.
- Latency:
  - COLLECT condition true at edge N → div_tvalid high after edge N+1.
  - gain_in handshake at edge M → ARM after M+1. Earliest swap is edge M+2.
  - Swap visible on gain_out_tdata immediately after the swapping edge. The first beat of the next packet sees the new gain.
- A non-tlast beat on an idle bus is never a boundary. That beat and the rest of its packet use the old gain.
- If a magnitude beat arrives on the same edge as REQUEST entry, the snapshot uses the pre-edge mag_reg and mag_fresh stays set.
- Asynchronous reset mid-transaction drops all valids immediately. The divider is reset together with this block.

## Structure
- Package agc_seq_pkg holds:
  - state enum;
  - SR_CTRL bit positions (CTRL_EN=0, CTRL_FREEZE=1, CTRL_PERIOD_LSB=8);
  - unity-gain constant function.
- Settings use three setting_reg instances.
- One sub-module, pkt_boundary_mon, owns in_pkt, pkt_cnt and the boundary-edge strobe.

## Test plan
- Enable with period=1, mag=0x1000, divider returns 0x4000. The gain swaps at the first tlast after return, and the mid-packet gain_out stays 0x2000.
- Period=4. Magnitudes are sent every packet. Exactly one div handshake occurs per 4 tlast beats over 20 packets.
- max_gain=0x3000 and divider returns 0xF000: gain_out becomes 0x3000.
- Freeze set during WAIT_GAIN: the result is consumed and discarded, gain_out is unchanged, and no new requests are issued until freeze clears.
- Disable during REQUEST with div_tready held low 5 cycles: div_tvalid stays high until the handshake. Then the result is drained, and gain_out reverts to default_gain at the next boundary edge.
- Reset asserted in ARM: all outputs take their reset values asynchronously, and gain_out=DEFAULT_GAIN one cycle after release.
